// File: rtl/riscv_param_pkg.sv
// Shared RISC-V pipeline parameters: bus widths, exception bit indices,
// memory size codes, LSU FSM encoding, bus structs and small helpers.
package riscv_param;

  localparam int EXU_LSU_BUS_WIDTH = 186;
  localparam int LSU_WBU_BUS_WIDTH = 117;
  localparam int EXCP_WIDTH        = 9;

  // Exception bits owned by the LSU; the rest pass straight through.
  localparam int EXCP_LD_MISALIGN = 4;
  localparam int EXCP_LD_FAULT    = 5;
  localparam int EXCP_ST_MISALIGN = 6;
  localparam int EXCP_ST_FAULT    = 7;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_OUT  = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic        skip_difftest;
    logic [31:0] pc;
    logic        csr_we;
    logic [31:0] final_result;
    logic        gr_we;
    logic [4:0]  rd;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        xret_flush;
  } lsu_wbu_bus_t;

  typedef struct packed {
    logic         mem_re;
    logic         mem_we;
    logic [1:0]   mem_size;
    logic         mem_unsigned;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    lsu_wbu_bus_t wb;
  } exu_lsu_bus_t;

  // Byte accesses never misalign; size code 3 is treated like a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] wstrb_of(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_B:  return 4'b0001 << lo;
      SIZE_H:  return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane the size can land in.
  function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SIZE_B:  return {4{d[7:0]}};
      SIZE_H:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half from a 32-bit read
// word and sign- or zero-extends it. Purely combinational.
//   addr_lo     : low two address bits of the access
//   size        : SIZE_B / SIZE_H / SIZE_W
//   is_unsigned : zero-extend instead of sign-extend
//   data        : raw word returned by memory
//   result      : extended load value
module lsu_load_align
  import riscv_param::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] data,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = data >> {addr_lo, 3'b000};
    case (size)
      SIZE_B:  result = is_unsigned ? {24'h0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_H:  result = is_unsigned ? {16'h0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/lsu_core.sv
// Load/store unit: takes one instruction at a time from EXU, issues at most
// one memory request, folds the response into the WBU bus and exception bits.
//   exu_*      : instruction from EXU (valid, packed bus, exception bits)
//   lsu_ready_o: high only while idle
//   mem_req_*  : word-aligned request, valid/ready handshake
//   mem_resp_* : response, always accepted while waiting for it
//   lsu_*/wbu_ready_i : result to WBU, held stable until taken
//   flush_i    : pipeline flush; kills the instruction without aborting the bus
module lsu_core
  import riscv_param::*;
#(
  parameter logic [31:0] DEV_BASE = 32'ha000_0000,
  parameter logic [31:0] DEV_MASK = 32'hf000_0000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         exu_valid_i,
  input  logic [EXU_LSU_BUS_WIDTH-1:0] exu_lsu_bus_i,
  input  logic [EXCP_WIDTH-1:0]        exu_excp_bus_i,
  output logic                         lsu_ready_o,
  output logic                         mem_req_valid_o,
  input  logic                         mem_req_ready_i,
  output logic                         mem_req_we_o,
  output logic [31:0]                  mem_req_addr_o,
  output logic [31:0]                  mem_req_wdata_o,
  output logic [3:0]                   mem_req_wstrb_o,
  input  logic                         mem_resp_valid_i,
  input  logic [31:0]                  mem_resp_data_i,
  input  logic                         mem_resp_err_i,
  output logic                         lsu_valid_o,
  output logic [LSU_WBU_BUS_WIDTH-1:0] lsu_wbu_bus_o,
  output logic [EXCP_WIDTH-1:0]        lsu_excp_bus_o,
  input  logic                         wbu_ready_i,
  input  logic                         flush_i
);

  exu_lsu_bus_t    in_bus;
  lsu_wbu_bus_t    wb_in, wb_q;
  lsu_state_e      state_q, state_d;
  logic            flush_pend_q;
  logic [EXCP_WIDTH-1:0] excp_q, mis_bits;
  logic            accept, acc, mis, go_mem, dev_hit;
  logic            is_store_q, uns_q;
  logic [1:0]      addr_lo_q, size_q;
  logic [31:0]     req_addr_q, req_wdata_q, ld_result;
  logic [3:0]      req_wstrb_q;
  logic            resp_fire;

  assign in_bus    = exu_lsu_bus_i;
  assign accept    = exu_valid_i && lsu_ready_o && !flush_i;
  assign acc       = in_bus.mem_re | in_bus.mem_we;
  assign mis       = acc && is_misaligned(in_bus.mem_size, in_bus.mem_addr[1:0]);
  assign go_mem    = acc && !mis && (exu_excp_bus_i == '0);
  assign dev_hit   = (in_bus.mem_addr & DEV_MASK) == DEV_BASE;
  assign resp_fire = (state_q == LSU_RESP) && mem_resp_valid_i;

  always_comb begin
    wb_in = in_bus.wb;
    wb_in.skip_difftest = in_bus.wb.skip_difftest | (acc && dev_hit);
    mis_bits = '0;
    if (mis) mis_bits[in_bus.mem_we ? EXCP_ST_MISALIGN : EXCP_LD_MISALIGN] = 1'b1;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= LSU_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    lsu_ready_o     = 1'b0;
    mem_req_valid_o = 1'b0;
    lsu_valid_o     = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        lsu_ready_o = 1'b1;
        if (accept) state_d = go_mem ? LSU_REQ : LSU_OUT;
      end
      LSU_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = LSU_RESP;
      end
      LSU_RESP: begin
        // A flushed access still drains its response, then drops silently.
        if (mem_resp_valid_i) state_d = (flush_pend_q || flush_i) ? LSU_IDLE : LSU_OUT;
      end
      LSU_OUT: begin
        lsu_valid_o = !flush_i;
        if (flush_i || wbu_ready_i) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        flush_pend_q <= 1'b0;
    else if (state_d == LSU_IDLE)     flush_pend_q <= 1'b0;
    else if (flush_i && (state_q == LSU_REQ || state_q == LSU_RESP))
                                      flush_pend_q <= 1'b1;
  end

  // ---------------- datapath ----------------
  lsu_load_align u_align (
    .addr_lo     (addr_lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (mem_resp_data_i),
    .result      (ld_result)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_q        <= '0;
      excp_q      <= '0;
      is_store_q  <= 1'b0;
      uns_q       <= 1'b0;
      addr_lo_q   <= 2'b00;
      size_q      <= 2'b00;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
    end else if (accept) begin
      wb_q        <= wb_in;
      excp_q      <= exu_excp_bus_i | mis_bits;
      is_store_q  <= in_bus.mem_we;
      uns_q       <= in_bus.mem_unsigned;
      addr_lo_q   <= in_bus.mem_addr[1:0];
      size_q      <= in_bus.mem_size;
      req_addr_q  <= {in_bus.mem_addr[31:2], 2'b00};
      req_wdata_q <= in_bus.mem_we ? wdata_rep(in_bus.mem_size, in_bus.mem_wdata) : 32'h0;
      req_wstrb_q <= in_bus.mem_we ? wstrb_of(in_bus.mem_size, in_bus.mem_addr[1:0]) : 4'h0;
    end else if (resp_fire) begin
      if (mem_resp_err_i) begin
        excp_q[is_store_q ? EXCP_ST_FAULT : EXCP_LD_FAULT] <= 1'b1;
        wb_q.gr_we <= 1'b0;
      end else if (!is_store_q) begin
        wb_q.final_result <= ld_result;
      end
    end
  end

  assign mem_req_we_o    = is_store_q;
  assign mem_req_addr_o  = req_addr_q;
  assign mem_req_wdata_o = req_wdata_q;
  assign mem_req_wstrb_o = req_wstrb_q;
  assign lsu_wbu_bus_o   = wb_q;
  assign lsu_excp_bus_o  = excp_q;

endmodule

// File: doc/lsu_core.md
LSU_CORE -- requirements
Module: lsu_core

Interface
REQ-001 Parameter DEV_BASE, default 32'ha000_0000, base of device (MMIO) window.
REQ-002 Parameter DEV_MASK, default 32'hf000_0000, mask: addr&DEV_MASK==DEV_BASE selects device window.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 exu_valid_i  in  1  EXU->LSU bus holds a valid instruction.
REQ-006 exu_lsu_bus_i  in  EXU_LSU_BUS_WIDTH (186)  {mem_re, mem_we, mem_size[1:0], mem_unsigned, mem_addr[31:0], mem_wdata[31:0], wb fields[116:0]}.
REQ-007 exu_excp_bus_i  in  9  exception bits from earlier stages.
REQ-008 lsu_ready_o  out  1  LSU accepts exu bus this cycle.
REQ-009 mem_req_valid_o / mem_req_ready_i  out/in  1/1  memory request handshake.
REQ-010 mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_wstrb_o  out  1/32/32/4  request payload; addr word-aligned.
REQ-011 mem_resp_valid_i, mem_resp_data_i, mem_resp_err_i  in  1/32/1  response; always accepted (no resp ready).
REQ-012 lsu_valid_o  out  1  WBU bus valid.
REQ-013 lsu_wbu_bus_o  out  LSU_WBU_BUS_WIDTH (117)  {skip_difftest, pc[31:0], csr_we, final_result[31:0], gr_we, rd[4:0], csr_addr[11:0], csr_wdata[31:0], xret_flush}, MSB first.
REQ-014 lsu_excp_bus_o  out  9  exception bits to WBU.
REQ-015 wbu_ready_i  in  1  WBU accepts.
REQ-016 flush_i  in  1  OR of WBU excp_flush and mret_flush.

Function
REQ-017 FSM states IDLE, REQ, RESP, OUT; one instruction in flight.
REQ-018 lsu_ready_o = (state==IDLE); accept on exu_valid_i && lsu_ready_o && !flush_i, latching bus and excp into internal registers.
REQ-019 Accepted, no access (mem_re=mem_we=0, or any exu_excp bit set, or misaligned): IDLE->OUT; lsu_valid_o high the next cycle.
REQ-020 Misalignment: size 1 with addr[0], size 2 with addr[1:0]!=0; sets excp bit4 (load) or bit6 (store); no bus request.
REQ-021 Accepted aligned access: IDLE->REQ; mem_req_valid_o held high with stable payload until mem_req_ready_i; then REQ->RESP.
REQ-022 wstrb: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; wdata replicated per lane; 0 for loads.
REQ-023 RESP: on mem_resp_valid_i -> OUT; mem_resp_err_i sets excp bit5 (load) or bit7 (store), clears gr_we.
REQ-024 Load result: select lane by addr[1:0], sign-extend unless mem_unsigned; replaces final_result; stores pass final_result unchanged.
REQ-025 skip_difftest out = incoming skip_difftest OR (access && address in device window).
REQ-026 OUT: lsu_valid_o=1; on wbu_ready_i -> IDLE; else hold all outputs stable.
REQ-027 Excp bits 0-3,8 pass through unchanged; 4-7 OR of incoming and LSU-detected.
REQ-028 flush_i in OUT: lsu_valid_o forced 0 that cycle, -> IDLE.
REQ-029 flush_i in REQ/RESP: transaction completes (valid not withdrawn, response drained), then -> IDLE without asserting lsu_valid_o.
REQ-030 flush_i in IDLE with exu_valid_i: instruction not accepted.
REQ-031 Response arriving same cycle as request handshake not permitted by memory; ignored outside RESP.

Reset
REQ-032 Async reset: state=IDLE, flush-pending=0, lsu_valid_o=0, mem_req_valid_o=0, lsu_ready_o=1, payload registers 0, lsu_excp_bus_o=0.
REQ-033 Reset mid-transaction abandons it; memory side shares the same reset.

Structure
REQ-034 EXU_LSU_BUS_WIDTH, LSU_WBU_BUS_WIDTH, excp bit indices, FSM state encoding, size codes in shared riscv_param package.
REQ-035 One sub-module lsu_load_align: combinational lane select and extension (addr[1:0], size, unsigned, data).

Verification
REQ-036 ALU op, exu_valid_i 1 cycle, final_result=0x1234 -> lsu_valid_o next cycle, final_result 0x1234, no mem_req_valid_o.
REQ-037 lb addr 0x8000_0003, resp data 0x80ff_ffff, ready after 2 cycles -> wstrb 0, result 0xffff_ff80; lbu -> 0x0000_0080.
REQ-038 sh addr 0x8000_0002 wdata 0xabcd -> wstrb 4'b1100, wdata 0xabcd_abcd, lsu_valid_o after response.
REQ-039 lw addr 0x8000_0002 -> no request, excp bit4, lsu_valid_o next cycle; mem_resp_err_i on lw 0x8000_0000 -> excp bit5, gr_we 0.
REQ-040 flush_i during RESP of lw 0xa000_0048 -> request completes, no lsu_valid_o, FSM IDLE; without flush skip_difftest=1.
REQ-041 wbu_ready_i low 3 cycles in OUT -> outputs stable, lsu_ready_o 0; reset asserted in REQ -> mem_req_valid_o 0 immediately.
